uart_vga_cs: RTL and testbench
==============================

Name: uart_vga_cs

Overview:
- Top-level control block.
- Receives command bytes on a UART line, decodes them into baud configuration and a 12-bit RGB colour register, and drives a 640x480@60 VGA output filled with that colour.
- A 16-bit LED bus exposes debug status, selected by two switches.

Parameters:
- CLKS_PER_BIT0, 46880, clocks per UART bit in default baud mode.
- CLKS_PER_BIT1, 93760, clocks per UART bit in slow (4800) mode.
- PIX_DIV, 4, clocks per VGA pixel (pixel-enable period).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- in  in  1  UART RX line, idle high, asynchronous.
- btnHS  in  1  1 = invert HSYNC polarity.
- btnVS  in  1  1 = invert VSYNC polarity.
- btnUART  in  1  LED debug select: UART status.
- btnVGA  in  1  LED debug select: colour.
- HSYNC  out  1  VGA horizontal sync.
- VSYNC  out  1  VGA vertical sync.
- RED  out  4  VGA red.
- GREEN  out  4  VGA green.
- BLUE  out  4  VGA blue.
- LEDS  out  16  debug LEDs.

Behaviour:
- Reset values (rst=0 at a clk edge):
  - baud mode 0; colour register 0; error flags 0; last byte 0.
  - h/v counters 0; RED/GREEN/BLUE=0; LEDS=0.
  - Receiver returns to IDLE.
- RX synchroniser: `in` passes through a 2-FF synchroniser before any use.
- Frame format, 11 bit times: start 0, 8 data bits MSB first, even parity bit (data ^ parity == 0), stop 1.
- Receiver FSM: IDLE -> START -> DATA(8) -> PARITY -> STOP -> IDLE.
  - IDLE->START on synchronised falling edge.
  - START rechecked at half bit. If high, treat as glitch and return to IDLE.
  - All subsequent bits sampled at mid-bit using the current CLKS_PER_BIT.
- End of STOP sample, one-cycle frame_done:
  - parity_err = parity mismatch; frame_err = stop sample 0.
  - If either is set, the byte is discarded.
  - Otherwise last byte is updated and the decoder runs.
  - Flags are updated on every completed frame, not sticky.
- Decode of a good byte b:
  - b[7]=0: cmd_err=1.
  - b[7:5]=101: config. b[4:0]=0 -> mode 0; b[4:0]=1 -> mode 1; other -> cfg_err=1, mode unchanged.
  - b[7:5]=100: R=b[3:0].
  - b[7:5]=110: G=b[3:0].
  - b[7:5]=111: B=b[3:0].
  - cmd_err and cfg_err clear on the next good decoded byte.
- Baud change timing: takes effect from the next start bit, never mid-frame.
- Reset mid-frame: the frame is aborted and the receiver returns to IDLE.
- VGA timing, counters advancing on pixel enable (every PIX_DIV clocks):
  - h total 800: visible 640, front porch 16, sync 96, back porch 48.
  - v total 525: visible 480, front porch 10, sync 2, back porch 33.
  - Sync active-low, XOR'd with btnHS/btnVS.
  - RGB = colour register in the visible area, 0 otherwise.
  - Outputs registered.
  - Colour updates are visible from the next pixel.
- LEDS:
  - btnUART=1 (priority): {parity_err, frame_err, cmd_err, cfg_err, mode, 3'b0, last_byte}.
  - else btnVGA=1: {4'b0, R, G, B}.
  - else 0.

Decomposition:
- Shared package: frame length, opcodes (OP_CFG=101, OP_R=100, OP_G=110, OP_B=111), VGA timing constants.
- Natural sub-module: uart_vga_cs_rx (synchroniser, baud counter, receiver FSM, parity/stop check).
- Decoder, VGA timing and LED mux stay in the top level.

Test Plan:
- Reset, idle line, 1 full frame -> HSYNC period 800*PIX_DIV clks with 96*PIX_DIV low; VSYNC 2 lines low per 525; RGB=0; LEDS=0.
- Mode 0, send 0xA1 with parity 1 -> mode=1. With btnUART=1: LEDS=0x08A1. Following frames only decoded at 93760 clks/bit.
- Mode 1, send 0x00 with parity 0 -> cmd_err=1, colour unchanged. Same byte with parity 1 -> parity_err=1, last byte not updated.
- Mode 1, send 0xA3 -> cfg_err=1, mode stays 1. Stop bit driven 0 on any frame -> frame_err=1.
- Mode 1, send 0x8A, 0xC5, 0xEC -> RGB=A,5,C in visible area, 0 in blanking. With btnVGA=1, btnUART=0: LEDS=0x0A5C.
- btnHS=1 and btnVS=1 -> both syncs inverted. Reset asserted mid-frame -> receiver idle, registers cleared.

Source files
------------

// File: rtl/uart_vga_cs_pkg.sv
// Shared constants for the UART-controlled VGA colour block: frame layout,
// command opcodes, VGA 640x480@60 timing, receiver states and status flags.
package uart_vga_cs_pkg;

  // Data bits carried in each UART frame, sent MSB first.
  localparam int DATA_BITS = 8;

  // Command opcodes, held in the top three bits of a received byte.
  localparam logic [2:0] OP_R   = 3'b100;
  localparam logic [2:0] OP_CFG = 3'b101;
  localparam logic [2:0] OP_G   = 3'b110;
  localparam logic [2:0] OP_B   = 3'b111;

  // Horizontal timing, measured in pixels.
  localparam int H_VISIBLE    = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  // Vertical timing, measured in lines.
  localparam int V_VISIBLE    = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Receiver states.
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  // Status flags. The field order matches the top nibble of the LED status view.
  typedef struct packed {
    logic parity_err;
    logic frame_err;
    logic cmd_err;
    logic cfg_err;
  } status_t;

  // Even parity holds when the data bits and the parity bit together contain
  // an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~((^data) ^ par);
  endfunction

endpackage

// File: rtl/uart_vga_cs_rx.sv
// UART receiver. It synchronises the line, finds the start bit, samples every
// bit at mid-bit and reports each completed frame with its parity and stop checks.
module uart_vga_cs_rx
  import uart_vga_cs_pkg::*;
#(
  parameter int CLKS_PER_BIT0 = 46880,
  parameter int CLKS_PER_BIT1 = 93760
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       mode,
  output logic       done,
  output logic [7:0] data,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int MAX_BIT = (CLKS_PER_BIT0 > CLKS_PER_BIT1) ? CLKS_PER_BIT0 : CLKS_PER_BIT1;
  localparam int CW = $clog2(MAX_BIT + 1);
  localparam logic [CW-1:0] BIT0 = CW'(CLKS_PER_BIT0);
  localparam logic [CW-1:0] BIT1 = CW'(CLKS_PER_BIT1);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic          sync1, sync2, prev;
  logic          fall;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] bit_clks;
  logic [CW-1:0] half;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par;

  assign fall = prev & ~sync2;
  assign half = bit_clks >> 1;

  // Two-flop synchroniser plus one history flop for falling-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Frame FSM. The bit period is latched at the start edge, so a baud change never lands mid-frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_clks   <= BIT0;
      idx        <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      done       <= 1'b0;
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall) begin
            state    <= RX_START;
            cnt      <= '0;
            bit_clks <= mode ? BIT1 : BIT0;
          end
        end
        RX_START: begin
          if (cnt == half - 1'b1) begin
            cnt <= '0;
            if (sync2) begin
              state <= RX_IDLE;
            end else begin
              state <= RX_DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == bit_clks - 1'b1) begin
            cnt   <= '0;
            shreg <= {shreg[6:0], sync2};
            if (idx == LAST_IDX) begin
              state <= RX_PARITY;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (cnt == bit_clks - 1'b1) begin
            cnt   <= '0;
            par   <= sync2;
            state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == bit_clks - 1'b1) begin
            cnt        <= '0;
            done       <= 1'b1;
            data       <= shreg;
            parity_err <= ~even_parity_ok(shreg, par);
            frame_err  <= ~sync2;
            state      <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_vga_cs.sv
// Top level. It decodes UART command bytes into the baud mode and a 12-bit
// colour, fills a 640x480 VGA raster with that colour and drives debug LEDs.
module uart_vga_cs
  import uart_vga_cs_pkg::*;
#(
  parameter int CLKS_PER_BIT0 = 46880,
  parameter int CLKS_PER_BIT1 = 93760,
  parameter int PIX_DIV       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in,
  input  logic        btnHS,
  input  logic        btnVS,
  input  logic        btnUART,
  input  logic        btnVGA,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic [3:0]  RED,
  output logic [3:0]  GREEN,
  output logic [3:0]  BLUE,
  output logic [15:0] LEDS
);

  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_SYNC_START);
  localparam logic [9:0] HS_END   = 10'(H_SYNC_END);
  localparam logic [9:0] VS_START = 10'(V_SYNC_START);
  localparam logic [9:0] VS_END   = 10'(V_SYNC_END);

  logic          rx_done;
  logic [7:0]    rx_data;
  logic          rx_perr;
  logic          rx_ferr;
  logic          mode;
  logic [3:0]    red_q, green_q, blue_q;
  logic [7:0]    last_byte;
  status_t       status;
  logic [PW-1:0] pix_cnt;
  logic          pix_en;
  logic [9:0]    hcnt, vcnt;
  logic          visible;
  logic          hs_active, vs_active;

  uart_vga_cs_rx #(
    .CLKS_PER_BIT0(CLKS_PER_BIT0),
    .CLKS_PER_BIT1(CLKS_PER_BIT1)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .mode      (mode),
    .done      (rx_done),
    .data      (rx_data),
    .parity_err(rx_perr),
    .frame_err (rx_ferr)
  );

  // Command decoder. Line-error flags follow every frame; a bad frame is otherwise ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode      <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      last_byte <= '0;
      status    <= '0;
    end else if (rx_done) begin
      status.parity_err <= rx_perr;
      status.frame_err  <= rx_ferr;
      if (!rx_perr && !rx_ferr) begin
        last_byte      <= rx_data;
        status.cmd_err <= ~rx_data[7];
        status.cfg_err <= 1'b0;
        if (rx_data[7]) begin
          case (rx_data[7:5])
            OP_CFG: begin
              if (rx_data[4:0] == 5'd0) begin
                mode <= 1'b0;
              end else if (rx_data[4:0] == 5'd1) begin
                mode <= 1'b1;
              end else begin
                status.cfg_err <= 1'b1;
              end
            end
            OP_R:    red_q   <= rx_data[3:0];
            OP_G:    green_q <= rx_data[3:0];
            OP_B:    blue_q  <= rx_data[3:0];
            default: ;
          endcase
        end
      end
    end
  end

  assign pix_en = (pix_cnt == PIX_LAST);

  // Pixel-enable divider and raster counters, stepped once per pixel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_cnt <= '0;
      hcnt    <= '0;
      vcnt    <= '0;
    end else begin
      pix_cnt <= pix_en ? '0 : pix_cnt + 1'b1;
      if (pix_en) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  assign visible   = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hs_active = (hcnt >= HS_START) && (hcnt < HS_END);
  assign vs_active = (vcnt >= VS_START) && (vcnt < VS_END);

  // Registered video outputs. The syncs are active-low unless the matching button inverts them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      HSYNC <= 1'b1;
      VSYNC <= 1'b1;
      RED   <= '0;
      GREEN <= '0;
      BLUE  <= '0;
    end else begin
      HSYNC <= ~hs_active ^ btnHS;
      VSYNC <= ~vs_active ^ btnVS;
      RED   <= visible ? red_q   : 4'd0;
      GREEN <= visible ? green_q : 4'd0;
      BLUE  <= visible ? blue_q  : 4'd0;
    end
  end

  // Debug LED view. The UART status view takes priority over the colour view.
  always_ff @(posedge clk) begin
    if (!rst) begin
      LEDS <= '0;
    end else if (btnUART) begin
      LEDS <= {status, mode, 3'b000, last_byte};
    end else if (btnVGA) begin
      LEDS <= {4'b0000, red_q, green_q, blue_q};
    end else begin
      LEDS <= '0;
    end
  end

endmodule

// File: tb/tb_uart_vga_cs.sv
// Self-checking bench for uart_vga_cs with short bit periods and a 2-clock pixel.
// Each frame sent pushes its expected status LEDs onto a scoreboard queue,
// which is popped once the frame has had time to land.
module tb_uart_vga_cs;

  localparam int CPB0 = 16;
  localparam int CPB1 = 32;
  localparam int PIX  = 2;

  logic        clk;
  logic        rst;
  logic        in;
  logic        btnHS, btnVS, btnUART, btnVGA;
  logic        HSYNC, VSYNC;
  logic [3:0]  RED, GREEN, BLUE;
  logic [15:0] LEDS;

  int checks = 0;
  int errors = 0;

  logic [15:0] expQ[$];

  logic       m_mode, m_perr, m_ferr, m_cmd, m_cfg;
  logic [3:0] m_r, m_g, m_b;
  logic [7:0] m_last;

  int lowc, highc;
  bit ok;

  uart_vga_cs #(
    .CLKS_PER_BIT0(CPB0),
    .CLKS_PER_BIT1(CPB1),
    .PIX_DIV      (PIX)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .btnHS  (btnHS),
    .btnVS  (btnVS),
    .btnUART(btnUART),
    .btnVGA (btnVGA),
    .HSYNC  (HSYNC),
    .VSYNC  (VSYNC),
    .RED    (RED),
    .GREEN  (GREEN),
    .BLUE   (BLUE),
    .LEDS   (LEDS)
  );

  // 10 ns system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_mode = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_cmd = 1'b0; m_cfg = 1'b0;
    m_r = 4'h0; m_g = 4'h0; m_b = 4'h0; m_last = 8'h00;
  endtask

  // Reference behaviour for one received frame.
  task automatic modelFrame(input logic [7:0] d, input logic p, input logic s);
    m_perr = (^d) ^ p;
    m_ferr = ~s;
    if (!m_perr && !m_ferr) begin
      m_last = d;
      m_cmd  = ~d[7];
      m_cfg  = 1'b0;
      if (d[7]) begin
        case (d[6:5])
          2'b01: begin
            if (d[4:0] == 5'd0) m_mode = 1'b0;
            else if (d[4:0] == 5'd1) m_mode = 1'b1;
            else m_cfg = 1'b1;
          end
          2'b00: m_r = d[3:0];
          2'b10: m_g = d[3:0];
          default: m_b = d[3:0];
        endcase
      end
    end
  endtask

  function automatic logic [15:0] expUart();
    return {m_perr, m_ferr, m_cmd, m_cfg, m_mode, 3'b000, m_last};
  endfunction

  // Sends one frame at the baud the DUT is expected to be using, then scores the status view.
  task automatic applyStimulus(input string tag, input logic [7:0] d, input logic p, input logic s);
    int cpb;
    cpb = m_mode ? CPB1 : CPB0;
    modelFrame(d, p, s);
    expQ.push_back(expUart());
    in = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      in = d[i];
      repeat (cpb) @(negedge clk);
    end
    in = p;
    repeat (cpb) @(negedge clk);
    in = s;
    repeat (cpb) @(negedge clk);
    in = 1'b1;
    repeat (6) @(negedge clk);
    if (expQ.size() == 0) checkOutput({tag, "_queue"}, 32'd0, 32'd1);
    else checkOutput(tag, {16'd0, LEDS}, {16'd0, expQ.pop_front()});
  endtask

  // Counts clocks until HSYNC reaches the given level, bounded by a cycle budget.
  task automatic waitHsync(input logic lvl, input int maxc, output int cycles, output bit found);
    cycles = 0;
    found  = 1'b0;
    while (cycles < maxc) begin
      @(negedge clk);
      cycles++;
      if (HSYNC === lvl) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput("hsync_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b0; in = 1'b1;
    btnHS = 1'b0; btnVS = 1'b0; btnUART = 1'b0; btnVGA = 1'b0;
    modelReset();
    repeat (5) @(negedge clk);
    checkOutput("reset_leds", {16'd0, LEDS}, 32'd0);
    checkOutput("reset_rgb", {20'd0, RED, GREEN, BLUE}, 32'd0);
    rst = 1'b1;

    // HSYNC shape on an idle line.
    waitHsync(1'b0, 2000, lowc, ok);
    waitHsync(1'b1, 2000, lowc, ok);
    waitHsync(1'b0, 2000, highc, ok);
    checkOutput("hsync_low", lowc, 96 * PIX);
    checkOutput("hsync_period", lowc + highc, 800 * PIX);
    checkOutput("vsync_idle", {31'd0, VSYNC}, 32'd1);
    checkOutput("idle_leds", {16'd0, LEDS}, 32'd0);

    btnUART = 1'b1;
    applyStimulus("cfg_mode1", 8'hA1, 1'b1, 1'b1);
    applyStimulus("cmd_err", 8'h00, 1'b0, 1'b1);
    btnUART = 1'b0; btnVGA = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("colour_kept", {16'd0, LEDS}, {20'd0, m_r, m_g, m_b});
    btnUART = 1'b1; btnVGA = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus("parity_err", 8'h00, 1'b1, 1'b1);
    applyStimulus("cfg_err", 8'hA3, 1'b0, 1'b1);
    applyStimulus("frame_err", 8'h8A, 1'b1, 1'b0);
    applyStimulus("set_red", 8'h8A, 1'b1, 1'b1);
    applyStimulus("set_green", 8'hC5, 1'b0, 1'b1);
    applyStimulus("set_blue", 8'hEC, 1'b1, 1'b1);

    btnVGA = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("led_priority", {16'd0, LEDS}, {16'd0, expUart()});
    btnUART = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("led_colour", {16'd0, LEDS}, 32'h0A5C);

    // Colour in the visible area and black in horizontal blanking.
    waitHsync(1'b1, 2000, lowc, ok);
    waitHsync(1'b0, 2000, lowc, ok);
    repeat (10 * PIX) @(negedge clk);
    checkOutput("rgb_blank", {20'd0, RED, GREEN, BLUE}, 32'd0);
    repeat ((800 - 656) * PIX) @(negedge clk);
    checkOutput("rgb_visible", {20'd0, RED, GREEN, BLUE}, {20'd0, m_r, m_g, m_b});

    // Inverted sync polarity.
    btnHS = 1'b1; btnVS = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("vsync_inv", {31'd0, VSYNC}, 32'd0);
    waitHsync(1'b0, 2000, lowc, ok);
    waitHsync(1'b1, 2000, lowc, ok);
    waitHsync(1'b0, 2000, highc, ok);
    checkOutput("hsync_inv_pulse", highc, 96 * PIX);
    btnHS = 1'b0; btnVS = 1'b0;

    // Reset in the middle of a frame.
    btnUART = 1'b1; btnVGA = 1'b0;
    in = 1'b0;
    repeat (CPB1) @(negedge clk);
    in = 1'b1;
    repeat (3 * CPB1) @(negedge clk);
    rst = 1'b0; in = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midreset_rgb", {20'd0, RED, GREEN, BLUE}, 32'd0);
    rst = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("midreset_leds", {16'd0, LEDS}, 32'd0);

    // A start pulse shorter than half a bit is a glitch and must be ignored.
    in = 1'b0;
    repeat (3) @(negedge clk);
    in = 1'b1;
    repeat (12 * CPB0) @(negedge clk);
    checkOutput("glitch_ignored", {16'd0, LEDS}, {16'd0, expUart()});
    applyStimulus("after_reset", 8'h81, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
